// File: rtl/memory_stage_controller.sv
// Memory-stage sequencer: issues data-cache load/store, stalls upstream, controls MEM/WB capture.
// Latency: a memory op takes at least 3 cycles (detect, access, done); non-memory ops pass in 0.
// Backpressure: pipeline_stall_out holds upstream stages until cache_ready_in completes the access.
module memory_stage_controller #(
    parameter int STALL_COUNTER_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           mem_read_in,
    input  logic                           mem_write_in,
    input  logic                           flush_in,
    input  logic                           cache_ready_in,
    input  logic                           clear_counter_in,
    output logic                           cache_req_out,
    output logic                           cache_write_out,
    output logic                           pipeline_stall_out,
    output logic                           memreg_enable_out,
    output logic                           memreg_bubble_out,
    output logic                           protocol_error_out,
    output logic [STALL_COUNTER_WIDTH-1:0] stall_cycles_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [STALL_COUNTER_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [STALL_COUNTER_WIDTH-1:0] CNT_ONE = 1;

    state_t state, state_nxt;
    logic   write_latch, write_latch_nxt;
    logic   flushed, flushed_nxt;
    logic   op;

    assign op = mem_read_in | mem_write_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            write_latch <= 1'b0;
            flushed     <= 1'b0;
        end else begin
            state       <= state_nxt;
            write_latch <= write_latch_nxt;
            flushed     <= flushed_nxt;
        end
    end

    always_comb begin
        state_nxt          = state;
        write_latch_nxt    = write_latch;
        flushed_nxt        = flushed;
        cache_req_out      = 1'b0;
        cache_write_out    = 1'b0;
        pipeline_stall_out = 1'b0;
        memreg_enable_out  = 1'b1;
        memreg_bubble_out  = 1'b0;
        case (state)
            IDLE: begin
                if (op && flush_in) begin
                    memreg_bubble_out = 1'b1;
                end else if (op) begin
                    pipeline_stall_out = 1'b1;
                    memreg_enable_out  = 1'b0;
                    // read+write together resolves to a store
                    write_latch_nxt    = mem_write_in;
                    flushed_nxt        = 1'b0;
                    state_nxt          = ACCESS;
                end
            end
            ACCESS: begin
                cache_req_out      = 1'b1;
                cache_write_out    = write_latch;
                pipeline_stall_out = 1'b1;
                memreg_enable_out  = 1'b0;
                // a flush only marks the result; the cache access always completes
                if (flush_in) flushed_nxt = 1'b1;
                if (cache_ready_in) state_nxt = DONE;
            end
            DONE: begin
                memreg_bubble_out = flushed | flush_in;
                flushed_nxt       = 1'b0;
                state_nxt         = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            protocol_error_out <= 1'b0;
        end else if (state == IDLE && mem_read_in && mem_write_in) begin
            protocol_error_out <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_out <= '0;
        end else if (clear_counter_in) begin
            stall_cycles_out <= '0;
        end else if (pipeline_stall_out && stall_cycles_out != CNT_MAX) begin
            stall_cycles_out <= stall_cycles_out + CNT_ONE;
        end
    end

endmodule

// File: doc/memory_stage_controller.md
Name: memory_stage_controller

Overview:
- Sequences the memory stage of the Abejaruco pipeline: issues load/store accesses to the data cache, stalls upstream stages while an access is outstanding, and drives load-enable/bubble control for the MEM/WB memory registers.
- Sits between the EX/MEM register outputs, the data cache request port and the MEM/WB memory registers.
- Keeps a saturating stall-cycle counter for performance bring-up.

Parameters:
- STALL_COUNTER_WIDTH, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_read_in  in  1  EX/MEM instruction is a load.
- mem_write_in  in  1  EX/MEM instruction is a store.
- flush_in  in  1  squash the instruction currently in the memory stage.
- cache_ready_in  in  1  one-cycle pulse: cache access complete.
- clear_counter_in  in  1  synchronous clear of the stall counter.
- cache_req_out  out  1  access request to the data cache.
- cache_write_out  out  1  request is a store (valid while cache_req_out=1).
- pipeline_stall_out  out  1  hold PC, IF/ID, ID/EX and EX/MEM.
- memreg_enable_out  out  1  MEM/WB memory registers capture this cycle.
- memreg_bubble_out  out  1  force cu_reg_write and cu_mem_to_reg to 0 in captured MEM/WB entry.
- protocol_error_out  out  1  sticky: read and write asserted together.
- stall_cycles_out  out  STALL_COUNTER_WIDTH  count of stalled cycles.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, write_latch=0, flushed=0, protocol_error_out=0, stall_cycles_out=0.
- Reset outputs follow IDLE decode with no op present: cache_req_out=0, pipeline_stall_out=0, memreg_enable_out=1, memreg_bubble_out=0.
- Reset mid-access drops cache_req_out immediately; the cache must tolerate an abandoned request.
- op = mem_read_in | mem_write_in.
- FSM states: IDLE, ACCESS, DONE. Outputs are a combinational decode of state and inputs.
- IDLE, op=0:
  - enable=1, bubble=0, stall=0, req=0.
- IDLE, op=1, flush_in=1:
  - No access is issued; enable=1, bubble=1, stall=0.
  - Stay in IDLE.
- IDLE, op=1, flush_in=0:
  - stall=1, enable=0, req=0.
  - Latch write_latch=mem_write_in and flushed=0.
  - Next state ACCESS.
- ACCESS:
  - req=1, cache_write_out=write_latch, stall=1, enable=0.
  - flush_in=1 sets flushed=1. The access is never aborted.
  - cache_ready_in=1: next state DONE; otherwise remain in ACCESS.
- DONE:
  - req=0, stall=0, enable=1, bubble=flushed.
  - Next state IDLE; flushed clears on that transition.
  - flush_in asserted during DONE also forces bubble=1.
- Minimum memory-op latency is 3 cycles (IDLE detect, ACCESS with immediate ready, DONE).
- cache_ready_in outside ACCESS is ignored.
- Read and write asserted together in IDLE:
  - Treated as a store (write_latch=1).
  - protocol_error_out set to 1; it stays set until reset.
- Stall counter:
  - Increments by 1 each rising edge where pipeline_stall_out=1.
  - Saturates at 2^STALL_COUNTER_WIDTH-1.
  - clear_counter_in has priority over increment; clearing yields 0, not 1.
- cache_write_out=0 whenever cache_req_out=0.

Test Plan:
- Release reset, no ops for 5 cycles -> enable=1, stall=0, req=0, bubble=0, stall_cycles_out=0 throughout.
- Load, cache_ready_in pulsed on 4th ACCESS cycle -> stall high for 5 cycles, req high 4 cycles with write=0, DONE enable=1 bubble=0, stall_cycles_out=5.
- Store, cache_ready_in on 1st ACCESS cycle -> 3-cycle sequence, cache_write_out=1 during ACCESS; mem_read_in=mem_write_in=1 on a later op -> protocol_error_out=1, write issued.
- flush_in during 2nd ACCESS cycle of a load -> req held until ready, DONE bubble=1; flush with op in IDLE -> no req, enable=1, bubble=1.
- rst_n low mid-ACCESS -> req, stall and counter drop to 0 immediately, IDLE on release.
- STALL_COUNTER_WIDTH=3, 10 stalled cycles -> saturate at 7; clear_counter_in while stalled -> 0.
